// File: rtl/conversor_bcd_display.sv
// Signed binary to 7-segment digit codes using a shift-and-add-3 engine.
// Blanks leading zeros and places a minus sign just left of the top digit.
module conversor_bcd_display #(
    parameter int LARGURA   = 16,
    parameter int DIGITOS   = 5,
    parameter bit COM_SINAL = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       inicia,
    input  logic [LARGURA-1:0]         valor,
    output logic                       ocupado,
    output logic                       pronto,
    output logic [4*(DIGITOS+1)-1:0]   codigos
);

    localparam int CW = $clog2(LARGURA + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);
    localparam int NB = 4 * DIGITOS;
    localparam int NC = 4 * (DIGITOS + 1);

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        FORMATA
    } estado_t;

    estado_t            estado, estado_n;
    logic [LARGURA-1:0] mag, mag_n;
    logic [NB-1:0]      bcd, bcd_n, ajuste;
    logic [CW-1:0]      cont, cont_n;
    logic               neg, neg_n, neg_in;
    logic [NC-1:0]      cod_n;
    logic               pronto_n;
    int                 k;

    assign neg_in  = COM_SINAL && valor[LARGURA-1];
    assign ocupado = (estado != OCIOSO);

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= OCIOSO;
            mag     <= '0;
            bcd     <= '0;
            cont    <= '0;
            neg     <= 1'b0;
            codigos <= {(DIGITOS+1){4'hF}};
            pronto  <= 1'b0;
        end else begin
            estado  <= estado_n;
            mag     <= mag_n;
            bcd     <= bcd_n;
            cont    <= cont_n;
            neg     <= neg_n;
            codigos <= cod_n;
            pronto  <= pronto_n;
        end
    end

    // Next state: capture, one double-dabble step per cycle, then format
    always_comb begin
        estado_n = estado;
        mag_n    = mag;
        bcd_n    = bcd;
        cont_n   = cont;
        neg_n    = neg;
        cod_n    = codigos;
        pronto_n = 1'b0;
        ajuste   = bcd;
        k        = 0;

        for (int i = 0; i < DIGITOS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                ajuste[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            if (bcd[4*i +: 4] != 4'd0)
                k = i;
        end

        unique case (estado)
            OCIOSO: begin
                if (inicia) begin
                    neg_n    = neg_in;
                    mag_n    = neg_in ? -valor : valor;
                    bcd_n    = '0;
                    cont_n   = '0;
                    estado_n = CONVERTE;
                end
            end
            CONVERTE: begin
                bcd_n  = {ajuste[NB-2:0], mag[LARGURA-1]};
                mag_n  = {mag[LARGURA-2:0], 1'b0};
                cont_n = cont + 1'b1;
                if (cont == ULTIMO)
                    estado_n = FORMATA;
            end
            FORMATA: begin
                cod_n = {(DIGITOS+1){4'hF}};
                for (int i = 0; i < DIGITOS; i++) begin
                    if (i <= k)
                        cod_n[4*i +: 4] = bcd[4*i +: 4];
                    else if (neg && i == k + 1)
                        cod_n[4*i +: 4] = 4'hA;
                end
                if (neg && k == DIGITOS - 1)
                    cod_n[NB +: 4] = 4'hA;
                pronto_n = 1'b1;
                estado_n = OCIOSO;
            end
            default: estado_n = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_conversor_bcd_display.sv
// Bench for conversor_bcd_display: directed cases plus random values
// compared against an arithmetic model of the digit/sign layout.
module tb_conversor_bcd_display;

    logic        clock = 1'b0;
    logic        reset;
    logic        inicia;
    logic [15:0] valor;
    logic        ocupado;
    logic        pronto;
    logic [23:0] codigos;

    int checks = 0;
    int errors = 0;

    conversor_bcd_display dut (
        .clock   (clock),
        .reset   (reset),
        .inicia  (inicia),
        .valor   (valor),
        .ocupado (ocupado),
        .pronto  (pronto),
        .codigos (codigos)
    );

    always #5 clock = ~clock;

    // Expected fields from decimal arithmetic on the signed value
    function automatic logic [23:0] modelo(input logic [15:0] v);
        int m;
        int k;
        bit neg;
        int d[5];
        logic [23:0] r;
        neg = v[15];
        m = neg ? 65536 - int'(v) : int'(v);
        for (int i = 0; i < 5; i++) begin
            d[i] = m % 10;
            m = m / 10;
        end
        k = 0;
        for (int i = 0; i < 5; i++)
            if (d[i] != 0) k = i;
        r = 24'hFFFFFF;
        for (int i = 0; i < 5; i++)
            if (i <= k) r[4*i +: 4] = 4'(d[i]);
        if (neg) r[4*(k+1) +: 4] = 4'hA;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full conversion with latency, busy width and result checks
    task automatic run_conv(input logic [15:0] v, input logic [23:0] exp,
                            input string tag);
        int busy;
        int np;
        int pidx;
        logic [23:0] cap;
        @(negedge clock);
        valor  = v;
        inicia = 1'b1;
        @(posedge clock);
        #1;
        inicia = 1'b0;
        valor  = 16'($urandom);
        busy = 0;
        np   = 0;
        pidx = -1;
        cap  = 'x;
        for (int n = 0; n < 20; n++) begin
            if (ocupado) busy++;
            if (pronto) begin
                np++;
                pidx = n;
                cap  = codigos;
            end
            @(posedge clock);
            #1;
        end
        chk({tag, "_busy"}, busy, 17);
        chk({tag, "_npronto"}, np, 1);
        chk({tag, "_lat"}, pidx, 17);
        chk({tag, "_cod"}, {8'h0, cap}, {8'h0, exp});
    endtask

    initial begin
        int n;
        int np;
        logic [15:0] rv;

        reset  = 1'b1;
        inicia = 1'b0;
        valor  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("rst_cod", {8'h0, codigos}, 32'h00FFFFFF);
        chk("rst_ocupado", {31'h0, ocupado}, 0);
        chk("rst_pronto", {31'h0, pronto}, 0);

        run_conv(16'd1234, 24'hFF1234, "v1234");
        run_conv(16'hFFF9, 24'hFFFFA7, "vm7");
        run_conv(16'd0,    24'hFFFFF0, "v0");
        run_conv(16'h8000, 24'hA32768, "vmin");
        run_conv(16'h7FFF, 24'hF32767, "vmax");

        // Re-pulse while busy is ignored; new start in pronto cycle accepted
        @(negedge clock);
        valor  = 16'd1234;
        inicia = 1'b1;
        @(posedge clock);
        #1;
        inicia = 1'b0;
        n = 0;
        repeat (5) begin
            @(posedge clock);
            #1;
            n++;
        end
        @(negedge clock);
        valor  = 16'd555;
        inicia = 1'b1;
        @(posedge clock);
        #1;
        n++;
        inicia = 1'b0;
        while (!pronto && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("ign_lat", n, 17);
        chk("ign_cod", {8'h0, codigos}, 32'h00FF1234);
        inicia = 1'b1;
        valor  = 16'hFFF9;
        @(posedge clock);
        #1;
        inicia = 1'b0;
        n = 1;
        while (!pronto && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("b2b_gap", n, 18);
        chk("b2b_cod", {8'h0, codigos}, 32'h00FFFFA7);

        // Reset in the middle of a conversion
        @(negedge clock);
        valor  = 16'd999;
        inicia = 1'b1;
        @(posedge clock);
        #1;
        inicia = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_ocupado", {31'h0, ocupado}, 0);
        chk("abort_cod", {8'h0, codigos}, 32'h00FFFFFF);
        chk("abort_pronto", {31'h0, pronto}, 0);
        @(negedge clock);
        reset = 1'b0;
        np = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (pronto) np++;
        end
        chk("abort_nopronto", np, 0);
        chk("abort_hold", {8'h0, codigos}, 32'h00FFFFFF);
        run_conv(16'd999, 24'hFFF999, "v999");

        // Random values against the model
        for (int t = 0; t < 16; t++) begin
            rv = 16'($urandom);
            run_conv(rv, modelo(rv), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
